// File: rtl/spi_slv16.sv
// rtl/spi_slv16.sv - 16-bit SPI slave (SCLK idles high) with synchronized inputs
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   SS_n, SCLK, MOSI  asynchronous SPI pins from the master
//   MISO              serial response, MSB first, 0 when not selected
//   tx_data, wrt      response word and its load strobe (into tx_buf)
//   rx_data, rdy      last good 16-bit word and its valid flag
//   clr_rdy           clears rdy
//   frm_err           one-cycle pulse on a frame with the wrong bit count
//   busy              high while a frame is being shifted

module spi_slv16 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] tx_data,
    input  logic        wrt,
    input  logic        clr_rdy,
    output logic [15:0] rx_data,
    output logic        rdy,
    output logic        frm_err,
    output logic        busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ss_dly_q, ss_dly_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic [SYNC_STAGES:0]   vld_q, vld_d;
    logic [15:0]            tx_buf_q, tx_buf_d;
    logic [15:0]            tx_shreg_q, tx_shreg_d;
    logic [15:0]            rx_shreg_q, rx_shreg_d;
    logic [15:0]            rx_data_q, rx_data_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic                   rdy_q, rdy_d;
    logic                   rdy_set_q, rdy_set_d;
    logic                   frm_err_q, frm_err_d;
    logic                   busy_q, busy_d;

    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // vld_q fills with ones after reset; its top bit says the edge-detect
    // flops hold real pin history rather than reset values. This keeps a
    // reset released with SS_n already low from looking like a frame start.
    assign ss_fall   = vld_q[SYNC_STAGES] & ss_dly_q & ~ss_s;
    assign ss_rise   = ~ss_dly_q & ss_s;
    assign sclk_rise = ~sclk_dly_q & sclk_s;
    assign sclk_fall = sclk_dly_q & ~sclk_s;

    assign MISO    = ~ss_s & tx_shreg_q[15];
    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign busy    = busy_q;

    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        ss_dly_d    = ss_s;
        sclk_dly_d  = sclk_s;
        vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};

        state_d    = state_q;
        tx_buf_d   = wrt ? tx_data : tx_buf_q;
        tx_shreg_d = tx_shreg_q;
        rx_shreg_d = rx_shreg_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        rdy_set_d  = 1'b0;
        frm_err_d  = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                // SCLK edges in IDLE (including one coincident with the
                // SS_n fall) are not part of any frame.
                if (ss_fall) begin
                    state_d    = SHIFT;
                    busy_d     = 1'b1;
                    tx_shreg_d = wrt ? tx_data : tx_buf_q;
                    bit_cnt_d  = 5'd0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (bit_cnt_q == 5'd16) begin
                        rx_data_d = rx_shreg_q;
                        rdy_set_d = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_shreg_d = {rx_shreg_q[14:0], mosi_s};
                        if (bit_cnt_q != 5'd31) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                    // The first fall of a frame keeps the MSB in place so
                    // the master samples it on the first rise.
                    if (sclk_fall && bit_cnt_q != 5'd0) begin
                        tx_shreg_d = {tx_shreg_q[14:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rdy_d = rdy_q;
        if (clr_rdy || ss_fall) begin
            rdy_d = 1'b0;
        end
        if (rdy_set_q) begin
            rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ss_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            ss_dly_q    <= 1'b1;
            sclk_dly_q  <= 1'b1;
            vld_q       <= '0;
            tx_buf_q    <= 16'h0000;
            tx_shreg_q  <= 16'h0000;
            rx_shreg_q  <= 16'h0000;
            rx_data_q   <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            rdy_q       <= 1'b0;
            rdy_set_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_dly_q    <= ss_dly_d;
            sclk_dly_q  <= sclk_dly_d;
            vld_q       <= vld_d;
            tx_buf_q    <= tx_buf_d;
            tx_shreg_q  <= tx_shreg_d;
            rx_shreg_q  <= rx_shreg_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            rdy_q       <= rdy_d;
            rdy_set_q   <= rdy_set_d;
            frm_err_q   <= frm_err_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_slv16.sv
// tb/tb_spi_slv16.sv - directed self-checking bench for spi_slv16
`timescale 1ns/1ps

module tb_spi_slv16;

    logic        clk;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [15:0] tx_data;
    logic        wrt;
    logic        clr_rdy;
    logic [15:0] rx_data;
    logic        rdy;
    logic        frm_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;

    spi_slv16 #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .wrt     (wrt),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle frm_err is high; a clean one-cycle pulse adds one.
    always @(negedge clk) begin
        if (frm_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [15:0] v);
        @(negedge clk);
        tx_data = v;
        wrt     = 1'b1;
        @(negedge clk);
        wrt     = 1'b0;
    endtask

    // Master frame, SCLK idles high: drive on fall, sample MISO before rise.
    // hook_kind 1 = wrt of hook_val before bit hook_bit, 2 = rst pulse there.
    task automatic do_frame(input logic [15:0] mosi_w, input int nbits,
                            input int hook_bit, input int hook_kind,
                            input logic [15:0] hook_val,
                            output logic [15:0] miso_w, output logic busy_mid);
        miso_w = 16'h0000;
        SS_n   = 1'b0;
        wait_clk(8);
        busy_mid = busy;
        for (int i = 0; i < nbits; i++) begin
            if (i == hook_bit && hook_kind == 1) load_tx(hook_val);
            if (i == hook_bit && hook_kind == 2) begin
                rst = 1'b1;
                wait_clk(2);
                rst = 1'b0;
            end
            SCLK = 1'b0;
            MOSI = mosi_w[15-i];
            wait_clk(8);
            miso_w = {miso_w[14:0], MISO};
            SCLK = 1'b1;
            wait_clk(8);
        end
        SS_n = 1'b1;
        wait_clk(10);
    endtask

    logic [15:0] miso_w;
    logic        bm;
    int          fe0;
    logic [15:0] rtx, rrx;

    initial begin
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        tx_data = 16'h0000; wrt = 1'b0; clr_rdy = 1'b0;
        wait_clk(3);
        check_eq("rst_miso", MISO, 0);
        check_eq("rst_rdy", rdy, 0);
        check_eq("rst_frm_err", frm_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rx_data", rx_data, 0);
        rst = 1'b0;
        wait_clk(5);

        // Basic frame
        load_tx(16'hA5C3);
        fe0 = ferr_cnt;
        do_frame(16'h1234, 16, -1, 0, 16'h0, miso_w, bm);
        check_eq("f1_busy_mid", bm, 1);
        check_eq("f1_miso", miso_w, 16'hA5C3);
        check_eq("f1_rx", rx_data, 16'h1234);
        check_eq("f1_rdy", rdy, 1);
        check_eq("f1_busy_end", busy, 0);
        check_eq("f1_miso_idle", MISO, 0);
        check_eq("f1_ferr", ferr_cnt - fe0, 0);

        // clr_rdy then a new good frame
        @(negedge clk); clr_rdy = 1'b1;
        @(negedge clk); clr_rdy = 1'b0;
        check_eq("clr_rdy", rdy, 0);
        do_frame(16'hBEEF, 16, -1, 0, 16'h0, miso_w, bm);
        check_eq("f2_rx", rx_data, 16'hBEEF);
        check_eq("f2_rdy", rdy, 1);
        check_eq("f2_miso", miso_w, 16'hA5C3);

        // Short frame: 12 bits
        fe0 = ferr_cnt;
        do_frame(16'h7777, 12, -1, 0, 16'h0, miso_w, bm);
        check_eq("short_ferr", ferr_cnt - fe0, 1);
        check_eq("short_rx", rx_data, 16'hBEEF);
        check_eq("short_rdy", rdy, 0);

        // wrt mid-frame only affects the next frame
        load_tx(16'h3C5A);
        do_frame(16'h0F0F, 16, 5, 1, 16'hFFFF, miso_w, bm);
        check_eq("midwrt_miso", miso_w, 16'h3C5A);
        check_eq("midwrt_rx", rx_data, 16'h0F0F);
        do_frame(16'h0000, 16, -1, 0, 16'h0, miso_w, bm);
        check_eq("next_miso", miso_w, 16'hFFFF);
        check_eq("next_rx", rx_data, 16'h0000);

        // Reset at bit 8, SS_n held low afterwards
        fe0 = ferr_cnt;
        do_frame(16'hC3C3, 16, 8, 2, 16'h0, miso_w, bm);
        check_eq("rstmid_rdy", rdy, 0);
        check_eq("rstmid_rx", rx_data, 16'h0000);
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_ferr", ferr_cnt - fe0, 0);
        do_frame(16'h5A5A, 16, -1, 0, 16'h0, miso_w, bm);
        check_eq("postrst_rx", rx_data, 16'h5A5A);
        check_eq("postrst_rdy", rdy, 1);
        check_eq("postrst_miso", miso_w, 16'h0000);

        // Back-to-back random frames
        fe0 = ferr_cnt;
        for (int k = 0; k < 100; k++) begin
            rtx = 16'($urandom);
            rrx = 16'($urandom);
            load_tx(rtx);
            do_frame(rrx, 16, -1, 0, 16'h0, miso_w, bm);
            check_eq("rand_miso", miso_w, rtx);
            check_eq("rand_rx", rx_data, rrx);
        end
        check_eq("rand_ferr", ferr_cnt - fe0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
